// File: rtl/alu_ctrl_decoder_pkg.sv
// ALU decode package: ctrl codes, opcodes, decoded-entry struct and the
// combinational RV32I -> ALU control decode function.
package alu_pkg;

  localparam int unsigned IMM_W = 32;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [3:0]       ctrl;
    logic             use_imm;
    logic [IMM_W-1:0] imm;
    logic             is_branch;
    logic             br_ne;
    logic             illegal;
  } dec_t;

  function automatic logic [IMM_W-1:0] imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [IMM_W-1:0] imm_s(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:25], instr[11:7]};
  endfunction

  function automatic logic [IMM_W-1:0] imm_b(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  function automatic logic [IMM_W-1:0] imm_u(input logic [31:0] instr);
    return {instr[31:12], 12'b0};
  endfunction

  function automatic logic [IMM_W-1:0] imm_j(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

  function automatic dec_t decode(input logic [31:0] instr);
    dec_t       d;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op     = instr[6:0];
    f3     = instr[14:12];
    f7     = instr[31:25];
    d      = '0;
    d.ctrl = ALU_ADD;
    case (op)
      OP_R: begin
        case ({f7, f3})
          {F7_BASE, F3_ADD}: d.ctrl = ALU_ADD;
          {F7_ALT,  F3_ADD}: d.ctrl = ALU_SUB;
          {F7_BASE, F3_AND}: d.ctrl = ALU_AND;
          {F7_BASE, F3_OR }: d.ctrl = ALU_OR;
          default:           d.illegal = 1'b1;
        endcase
      end
      OP_I: begin
        d.use_imm = 1'b1;
        d.imm     = imm_i(instr);
        case (f3)
          F3_ADD:  d.ctrl = ALU_ADD;
          F3_AND:  d.ctrl = ALU_AND;
          F3_OR:   d.ctrl = ALU_OR;
          default: d.illegal = 1'b1;
        endcase
      end
      OP_LOAD: begin
        d.use_imm = 1'b1;
        d.imm     = imm_i(instr);
      end
      OP_STORE: begin
        d.use_imm = 1'b1;
        d.imm     = imm_s(instr);
      end
      OP_BRANCH: begin
        d.ctrl      = ALU_SUB;
        d.is_branch = 1'b1;
        d.imm       = imm_b(instr);
        case (f3)
          F3_BEQ:  d.br_ne = 1'b0;
          F3_BNE:  d.br_ne = 1'b1;
          default: d.illegal = 1'b1;
        endcase
      end
      OP_LUI, OP_AUIPC: begin
        d.use_imm = 1'b1;
        d.imm     = imm_u(instr);
      end
      OP_JAL: begin
        d.use_imm = 1'b1;
        d.imm     = imm_j(instr);
      end
      OP_JALR: begin
        d.use_imm = 1'b1;
        d.imm     = imm_i(instr);
        if (f3 != F3_ADD) d.illegal = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    // Illegal entries carry no operand info; the top substitutes its own ctrl code.
    if (d.illegal) begin
      d         = '0;
      d.illegal = 1'b1;
      d.ctrl    = ALU_ADD;
    end
    return d;
  endfunction

endpackage

// File: rtl/alu_ctrl_decoder_if.sv
// Instruction-in / decoded-entry-out handshake bundle of the ALU decode stage.
interface alu_ctrl_decoder_if #(
  parameter int unsigned XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      alu_ctrl;
  logic            use_imm;
  logic [XLEN-1:0] imm;
  logic            is_branch;
  logic            br_ne;
  logic            illegal;

  modport master (
    output flush, in_valid, instr, out_ready,
    input  in_ready, out_valid, alu_ctrl, use_imm, imm, is_branch, br_ne, illegal
  );

  modport slave (
    input  flush, in_valid, instr, out_ready,
    output in_ready, out_valid, alu_ctrl, use_imm, imm, is_branch, br_ne, illegal
  );
endinterface

// File: rtl/alu_ctrl_decoder_skid.sv
// Generic 2-entry valid/ready skid buffer with synchronous flush; in_ready and
// out_valid come straight from the occupancy register.
module rv_skid_buf
  import alu_pkg::*;
#(
  parameter type T = dec_t
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  typedef enum logic [1:0] {
    SK_EMPTY,
    SK_MAIN,
    SK_FULL
  } skid_state_e;

  skid_state_e state_q, state_d;
  T            main_q, skid_q;
  logic        load_main_in, load_main_skid, load_skid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SK_EMPTY;
    else     state_q <= state_d;
  end

  // in_valid is only looked at outside SK_FULL, where in_ready is already 1.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      SK_EMPTY: begin
        if (in_valid) begin
          state_d      = SK_MAIN;
          load_main_in = 1'b1;
        end
      end
      SK_MAIN: begin
        if (out_ready) begin
          if (in_valid) load_main_in = 1'b1;
          else          state_d      = SK_EMPTY;
        end else if (in_valid) begin
          state_d   = SK_FULL;
          load_skid = 1'b1;
        end
      end
      SK_FULL: begin
        if (out_ready) begin
          state_d        = SK_MAIN;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = SK_EMPTY;
    endcase
    if (flush) begin
      state_d        = SK_EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)        main_q <= in_data;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_data;
    end
  end

  assign in_ready  = (state_q != SK_FULL);
  assign out_valid = (state_q != SK_EMPTY);
  assign out_data  = main_q;

endmodule

// File: rtl/alu_ctrl_decoder.sv
// Registered RV32I decode stage producing ALU ctrl, immediate and branch flags
// behind a valid/ready handshake with a 2-entry skid buffer.
module alu_ctrl_decoder
  import alu_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter logic [3:0]  ILLEGAL_OP = 4'b0010
) (
  input logic              clk,
  input logic              rst,
  alu_ctrl_decoder_if.slave bus
);

  dec_t dec_in, dec_q;

  always_comb begin
    dec_in = decode(bus.instr);
    if (dec_in.illegal) dec_in.ctrl = ILLEGAL_OP;
  end

  rv_skid_buf #(
    .T(dec_t)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (bus.flush),
    .in_valid (bus.in_valid),
    .in_ready (bus.in_ready),
    .in_data  (dec_in),
    .out_valid(bus.out_valid),
    .out_ready(bus.out_ready),
    .out_data (dec_q)
  );

  assign bus.alu_ctrl  = dec_q.ctrl;
  assign bus.use_imm   = dec_q.use_imm;
  assign bus.imm       = XLEN'(dec_q.imm);
  assign bus.is_branch = dec_q.is_branch;
  assign bus.br_ne     = dec_q.br_ne;
  assign bus.illegal   = dec_q.illegal;

endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// Self-checking bench for alu_ctrl_decoder: directed cases plus randomized
// instruction streams against an occupancy/queue reference model.
module tb_alu_ctrl_decoder;

  typedef struct {
    logic [3:0]  ctrl;
    logic        use_imm;
    logic [31:0] imm;
    logic        br;
    logic        ne;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t q[$];

  alu_ctrl_decoder_if #(.XLEN(32)) bus ();

  alu_ctrl_decoder #(
    .XLEN      (32),
    .ILLEGAL_OP(4'b0010)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] ctrl, input logic ui, input logic [31:0] imm,
                              input logic br, input logic ne, input logic ill);
    exp_t e;
    e.ctrl = ctrl; e.use_imm = ui; e.imm = imm; e.br = br; e.ne = ne; e.ill = ill;
    return e;
  endfunction

  // One cycle: drive at negedge, check against model, then advance model.
  task automatic step(input logic iv, input logic [31:0] ins, input exp_t e,
                      input logic ordy, input logic fl);
    logic model_rdy;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.instr     = ins;
    bus.out_ready = ordy;
    bus.flush     = fl;
    #1;
    model_rdy = (q.size() < 2);
    check("in_ready", 32'(bus.in_ready), 32'(model_rdy));
    check("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      check("alu_ctrl", 32'(bus.alu_ctrl), 32'(q[0].ctrl));
      check("use_imm", 32'(bus.use_imm), 32'(q[0].use_imm));
      check("imm", bus.imm, q[0].imm);
      check("is_branch", 32'(bus.is_branch), 32'(q[0].br));
      check("br_ne", 32'(bus.br_ne), 32'(q[0].ne));
      check("illegal", 32'(bus.illegal), 32'(q[0].ill));
    end
    if (fl) q.delete();
    else begin
      if (ordy && q.size() > 0) void'(q.pop_front());
      if (iv && model_rdy) q.push_back(e);
    end
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({pfx, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({pfx, "_alu_ctrl"}, 32'(bus.alu_ctrl), 32'd0);
    check({pfx, "_imm"}, bus.imm, 32'd0);
    check({pfx, "_flags"}, {29'd0, bus.use_imm, bus.is_branch, bus.br_ne}, 32'd0);
    check({pfx, "_illegal"}, 32'(bus.illegal), 32'd0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    q.delete();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    rst          = 1'b0;
  endtask

  // Builds an instruction from fields and knows its decode from how it was built.
  task automatic gen(input int unsigned kind, output logic [31:0] ins, output exp_t e);
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] v;
    logic [19:0] u;
    logic [11:0] r12;
    logic [24:0] r25;
    int          s;
    rd  = 5'($urandom);
    rs1 = 5'($urandom);
    rs2 = 5'($urandom);
    f3  = 3'($urandom);
    e   = mk(4'b0010, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    s   = int'($urandom_range(0, 4095)) - 2048;
    v   = s;
    case (kind)
      0: ins = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
      1: begin ins = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011}; e.ctrl = 4'b0110; end
      2: begin ins = {7'b0000000, rs2, rs1, 3'b111, rd, 7'b0110011}; e.ctrl = 4'b0000; end
      3: begin ins = {7'b0000000, rs2, rs1, 3'b110, rd, 7'b0110011}; e.ctrl = 4'b0001; end
      4: begin ins = {v[11:0], rs1, 3'b000, rd, 7'b0010011}; e.use_imm = 1; e.imm = v; end
      5: begin ins = {v[11:0], rs1, 3'b111, rd, 7'b0010011}; e.use_imm = 1; e.imm = v; e.ctrl = 4'b0000; end
      6: begin ins = {v[11:0], rs1, 3'b110, rd, 7'b0010011}; e.use_imm = 1; e.imm = v; e.ctrl = 4'b0001; end
      7: begin ins = {v[11:0], rs1, f3, rd, 7'b0000011}; e.use_imm = 1; e.imm = v; end
      8: begin ins = {v[11:5], rs2, rs1, f3, v[4:0], 7'b0100011}; e.use_imm = 1; e.imm = v; end
      9, 10: begin
        v   = s * 2;
        ins = {v[12], v[10:5], rs2, rs1, (kind == 10) ? 3'b001 : 3'b000, v[4:1], v[11], 7'b1100011};
        e.ctrl = 4'b0110; e.br = 1; e.ne = (kind == 10); e.imm = v;
      end
      11, 12: begin
        u   = 20'($urandom);
        ins = {u, rd, (kind == 11) ? 7'b0110111 : 7'b0010111};
        e.use_imm = 1; e.imm = u * 4096;
      end
      13: begin
        v   = (int'($urandom_range(0, 1048575)) - 524288) * 2;
        ins = {v[20], v[10:1], v[11], v[19:12], rd, 7'b1101111};
        e.use_imm = 1; e.imm = v;
      end
      14: begin ins = {v[11:0], rs1, 3'b000, rd, 7'b1100111}; e.use_imm = 1; e.imm = v; end
      default: begin
        e.ill = 1;
        r12   = 12'($urandom);
        r25   = 25'($urandom);
        case ($urandom_range(0, 7))
          0: ins = {7'b0000000, rs2, rs1, 3'($urandom_range(1, 5)), rd, 7'b0110011};
          1: ins = {7'b0000001, rs2, rs1, 3'b000, rd, 7'b0110011};
          2: ins = {7'b0100000, rs2, rs1, 3'b111, rd, 7'b0110011};
          3: ins = {r12, rs1, 3'($urandom_range(1, 5)), rd, 7'b0010011};
          4: ins = {r12[11:5], rs2, rs1, 3'($urandom_range(2, 7)), r12[4:0], 7'b1100011};
          5: ins = {r12, rs1, 3'($urandom_range(1, 7)), rd, 7'b1100111};
          6: ins = {r25, 7'b1110011};
          default: ins = {r25, 7'b0001111};
        endcase
      end
    endcase
  endtask

  initial begin
    logic [31:0] ins;
    exp_t        e;
    exp_t        nil;
    exp_t        e_add, e_sub, e_or;
    nil   = mk(4'b0000, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    e_add = mk(4'b0010, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    e_sub = mk(4'b0110, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    e_or  = mk(4'b0001, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    bus.in_valid  = 1'b0;
    bus.instr     = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed decodes
    step(1, 32'h002081B3, e_add, 1, 0);
    step(1, 32'h402081B3, e_sub, 1, 0);
    step(1, 32'hFFF00093, mk(4'b0010, 1, 32'hFFFFFFFF, 0, 0, 0), 1, 0);
    step(1, 32'h00208463, mk(4'b0110, 0, 32'h00000008, 1, 0, 0), 1, 0);
    step(1, 32'h0020C1B3, mk(4'b0010, 0, 32'h0, 0, 0, 1), 1, 0);
    step(1, 32'h002081B3, e_add, 1, 0);
    step(0, 32'h0, nil, 1, 0);
    step(0, 32'h0, nil, 1, 0);

    // Stall with three back-to-back words, then release
    step(1, 32'h002081B3, e_add, 0, 0);
    step(1, 32'h402081B3, e_sub, 0, 0);
    step(1, 32'h0020E1B3, e_or, 0, 0);
    step(1, 32'h0020E1B3, e_or, 0, 0);
    step(1, 32'h0020E1B3, e_or, 1, 0);
    step(1, 32'h0020E1B3, e_or, 1, 0);
    step(0, 32'h0, nil, 1, 0);
    step(0, 32'h0, nil, 1, 0);

    // Flush with skid full and a word presented
    step(1, 32'h002081B3, e_add, 0, 0);
    step(1, 32'h402081B3, e_sub, 0, 0);
    step(1, 32'h0020E1B3, e_or, 0, 1);
    step(0, 32'h0, nil, 1, 0);
    step(0, 32'h0, nil, 1, 0);

    // Reset in the middle of a stream
    step(1, 32'h002081B3, e_add, 0, 0);
    step(1, 32'h402081B3, e_sub, 0, 0);
    async_reset();
    step(0, 32'h0, nil, 1, 0);

    // Randomized streams
    for (int unsigned i = 0; i < 3000; i++) begin
      gen($urandom_range(0, 15), ins, e);
      step(($urandom_range(0, 99) < 70), ins, e, ($urandom_range(0, 99) < 60),
           ($urandom_range(0, 99) < 3));
      if (i % 700 == 699) async_reset();
    end
    step(0, 32'h0, nil, 1, 0);
    step(0, 32'h0, nil, 1, 0);
    step(0, 32'h0, nil, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
